// File: rtl/srp16_pkg.sv
// Shared SRP16 data-memory definitions: bus widths, responder states, captured request.
package srp16_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/srp16_dmem_responder_if.sv
// SRP16 load/store port between core (master) and data memory (slave).
// err exists only when SRP16_DMEM_RANGE_CHK_EN is defined.
interface srp16_dmem_responder_if #(
    parameter int unsigned DATA_W = srp16_pkg::DATA_W,
    parameter int unsigned ADDR_W = srp16_pkg::ADDR_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
`ifdef SRP16_DMEM_RANGE_CHK_EN
    logic              err;

    modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
`else
    modport master (output req, we, addr, wdata, input ack, rdata, busy);
    modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
`endif
endinterface

// File: rtl/srp16_dmem_array.sv
// Synchronous single-port RAM, DEPTH x DATA_W, write-enable and registered read.
module srp16_dmem_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        q
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/srp16_dmem_responder.sv
// SRP16 data-memory responder: captures one request, waits WAIT_CYCLES, acks with read data.
// Optional SRP16_DMEM_RANGE_CHK_EN adds the err flag for out-of-range accesses.
module srp16_dmem_responder #(
    parameter int unsigned DATA_W      = srp16_pkg::DATA_W,
    parameter int unsigned ADDR_W      = srp16_pkg::ADDR_W,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    srp16_dmem_responder_if.slave   bus
);
    import srp16_pkg::*;

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            state;
    req_t              cap;
    logic [3:0]        cnt;
    logic              ack_q;
    logic              busy_q;
    logic              rd_ok;
    logic [DATA_W-1:0] ram_q;

    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic              acc_in_range;
    logic              enter_resp;
    logic              ram_re;
    logic              ram_we;

    // The RAM read is issued on the edge entering RESP so data is ready in the
    // ack cycle; with zero wait that edge is the capture edge, so use the live bus.
    always_comb begin
        acc_addr     = (state == S_IDLE) ? bus.addr : cap.addr;
        acc_we       = (state == S_IDLE) ? bus.we   : cap.we;
        acc_in_range = (32'(acc_addr) < MEM_DEPTH);
        enter_resp   = 1'b0;
        if (state == S_IDLE && bus.req && WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
        end
        if (state == S_WAIT && cnt == LAST_CNT) begin
            enter_resp = 1'b1;
        end
        ram_re = enter_resp && !acc_we && acc_in_range;
        ram_we = (state == S_RESP) && cap.we && acc_in_range;
    end

`ifdef SRP16_DMEM_RANGE_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= !acc_in_range;
        end else begin
            err_q <= 1'b0;
        end
    end

    assign bus.err = err_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cap    <= '0;
            cnt    <= '0;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
            rd_ok  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        cap    <= '{we: bus.we, addr: bus.addr, wdata: bus.wdata};
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                            ack_q <= 1'b1;
                            rd_ok <= ram_re;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == LAST_CNT) begin
                        state <= S_RESP;
                        ack_q <= 1'b1;
                        rd_ok <= ram_re;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                    rd_ok  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    srp16_dmem_array #(
        .DEPTH  (MEM_DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (acc_addr[AW-1:0]),
        .wdata (cap.wdata),
        .q     (ram_q)
    );

    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rd_ok ? ram_q : '0;

endmodule

// File: tb/tb_srp16_dmem_responder.sv
// Directed bench for srp16_dmem_responder: one instance with WAIT_CYCLES=2 and one with 0.
// Checks err as well when SRP16_DMEM_RANGE_CHK_EN is defined.
module tb_srp16_dmem_responder;

    logic clk = 1'b0;
    logic rst_n;
    int   vec  = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    srp16_dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();
    srp16_dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

    srp16_dmem_responder #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus2)
    );

    srp16_dmem_responder #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    // sel = 1 addresses the WAIT_CYCLES=2 instance, sel = 0 the zero-wait one.
    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wdata = d;
        end else begin
            bus0.req = r; bus0.we = w; bus0.addr = a; bus0.wdata = d;
        end
    endtask

    function automatic logic get_ack(input bit sel);
        return sel ? bus2.ack : bus0.ack;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? bus2.busy : bus0.busy;
    endfunction

    function automatic logic [15:0] get_rdata(input bit sel);
        return sel ? bus2.rdata : bus0.rdata;
    endfunction

    function automatic logic get_err(input bit sel);
`ifdef SRP16_DMEM_RANGE_CHK_EN
        return sel ? bus2.err : bus0.err;
`else
        return sel ? 1'b0 : 1'b0;
`endif
    endfunction

    // Issues one transaction and measures it; lat counts cycles from the capture edge.
    task automatic run(input bit sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input bit perturb, output int lat, output int busy_n,
                       output logic [15:0] rd, output logic er, output int rd_bad);
        lat = -1; busy_n = 0; rd = '0; er = 1'b0; rd_bad = 0;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (perturb && i == 1) drive(sel, 1'b1, w, 16'h0020, 16'hFFFF);
            if (get_busy(sel)) busy_n++;
            if (get_ack(sel)) begin
                lat = i;
                rd  = get_rdata(sel);
                er  = get_err(sel);
                drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
                break;
            end else if (get_rdata(sel) !== 16'h0000) begin
                rd_bad++;
            end
        end
        if (lat < 0) drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        vec++; if (bus2.ack !== 1'b0) begin miss++; $display("FAIL rst_ack2: got %b want 0", bus2.ack); end
        vec++; if (bus2.busy !== 1'b0) begin miss++; $display("FAIL rst_busy2: got %b want 0", bus2.busy); end
        vec++; if (bus2.rdata !== 16'h0000) begin miss++; $display("FAIL rst_rdata2: got %h want 0000", bus2.rdata); end
        vec++; if (bus0.ack !== 1'b0) begin miss++; $display("FAIL rst_ack0: got %b want 0", bus0.ack); end
        vec++; if (bus0.busy !== 1'b0) begin miss++; $display("FAIL rst_busy0: got %b want 0", bus0.busy); end
        vec++; if (bus0.rdata !== 16'h0000) begin miss++; $display("FAIL rst_rdata0: got %h want 0000", bus0.rdata); end
        rst_n = 1'b1;
    endtask

    task automatic preload();
        int lat, bn, bad; logic [15:0] rd; logic er;
        run(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        run(1'b1, 1'b1, 16'h0005, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        run(1'b1, 1'b1, 16'h0020, 16'h0000, 1'b0, lat, bn, rd, er, bad);
    endtask

    task automatic test_write_read();
        int lat, bn, bad; logic [15:0] rd; logic er;
        run(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, lat, bn, rd, er, bad);
        vec++; if (lat !== 3) begin miss++; $display("FAIL w2_wr_lat: got %0d want 3", lat); end
        vec++; if (bn !== 3) begin miss++; $display("FAIL w2_wr_busy: got %0d cycles want 3", bn); end
        vec++; if (er !== 1'b0) begin miss++; $display("FAIL w2_wr_err: got %b want 0", er); end
        @(negedge clk);
        vec++; if (bus2.busy !== 1'b0 || bus2.ack !== 1'b0) begin
            miss++; $display("FAIL w2_after_ack: busy %b ack %b want 0 0", bus2.busy, bus2.ack);
        end
        run(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (lat !== 3) begin miss++; $display("FAIL w2_rd_lat: got %0d want 3", lat); end
        vec++; if (rd !== 16'hBEEF) begin miss++; $display("FAIL w2_rd_data: got %h want beef", rd); end
        vec++; if (bad !== 0) begin miss++; $display("FAIL w2_rd_idle_zero: got %0d nonzero cycles want 0", bad); end
        @(negedge clk);
        vec++; if (bus2.rdata !== 16'h0000) begin miss++; $display("FAIL w2_rd_post: got %h want 0000", bus2.rdata); end
    endtask

    task automatic test_back_to_back();
        int lat, bn, bad; logic [15:0] rd; logic er;
        run(1'b0, 1'b1, 16'h0001, 16'h1234, 1'b0, lat, bn, rd, er, bad);
        vec++; if (lat !== 1) begin miss++; $display("FAIL w0_wr_lat: got %0d want 1", lat); end
        vec++; if (bn !== 1) begin miss++; $display("FAIL w0_wr_busy: got %0d cycles want 1", bn); end
        run(1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (lat !== 1) begin miss++; $display("FAIL w0_rd_lat: got %0d want 1", lat); end
        vec++; if (rd !== 16'h1234) begin miss++; $display("FAIL w0_rd_data: got %h want 1234", rd); end
        run(1'b0, 1'b1, 16'h0001, 16'h4321, 1'b0, lat, bn, rd, er, bad);
        run(1'b0, 1'b0, 16'h0001, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (rd !== 16'h4321) begin miss++; $display("FAIL w0_rd_data2: got %h want 4321", rd); end
    endtask

    task automatic test_wait_change();
        int lat, bn, bad; logic [15:0] rd; logic er;
        run(1'b1, 1'b1, 16'h0011, 16'h5555, 1'b1, lat, bn, rd, er, bad);
        vec++; if (lat !== 3) begin miss++; $display("FAIL chg_wr_lat: got %0d want 3", lat); end
        run(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (rd !== 16'h5555) begin miss++; $display("FAIL chg_rd_0011: got %h want 5555", rd); end
        run(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (rd !== 16'h0000) begin miss++; $display("FAIL chg_rd_0020: got %h want 0000", rd); end
    endtask

    task automatic test_reset_mid();
        int lat, bn, bad, acks; logic [15:0] rd; logic er;
        acks = 0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 16'h0005, 16'hAAAA);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec++; if (bus2.ack !== 1'b0) begin miss++; $display("FAIL mid_rst_ack: got %b want 0", bus2.ack); end
        vec++; if (bus2.busy !== 1'b0) begin miss++; $display("FAIL mid_rst_busy: got %b want 0", bus2.busy); end
        vec++; if (bus2.rdata !== 16'h0000) begin miss++; $display("FAIL mid_rst_rdata: got %h want 0000", bus2.rdata); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus2.ack) acks++;
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus2.ack) acks++;
        end
        vec++; if (acks !== 0) begin miss++; $display("FAIL mid_rst_noack: got %0d acks want 0", acks); end
        run(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (rd !== 16'h0000) begin miss++; $display("FAIL mid_rst_rd_0005: got %h want 0000", rd); end
    endtask

    task automatic test_out_of_range();
        int lat, bn, bad; logic [15:0] rd; logic er;
        run(1'b1, 1'b1, 16'h0400, 16'h1111, 1'b0, lat, bn, rd, er, bad);
        vec++; if (lat !== 3) begin miss++; $display("FAIL oor_wr_lat: got %0d want 3", lat); end
`ifdef SRP16_DMEM_RANGE_CHK_EN
        vec++; if (er !== 1'b1) begin miss++; $display("FAIL oor_wr_err: got %b want 1", er); end
`endif
        run(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (lat !== 3) begin miss++; $display("FAIL oor_rd_lat: got %0d want 3", lat); end
        vec++; if (rd !== 16'h0000) begin miss++; $display("FAIL oor_rd_data: got %h want 0000", rd); end
`ifdef SRP16_DMEM_RANGE_CHK_EN
        vec++; if (er !== 1'b1) begin miss++; $display("FAIL oor_rd_err: got %b want 1", er); end
`endif
        run(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, lat, bn, rd, er, bad);
        vec++; if (rd !== 16'h0000) begin miss++; $display("FAIL oor_alias_0000: got %h want 0000", rd); end
    endtask

    task automatic test_hold_req();
        int nack; int t [3]; logic [15:0] rsum;
        nack = 0; rsum = '0; t[0] = -1; t[1] = -1; t[2] = -1;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus2.ack) begin
                if (nack < 3) t[nack] = i;
                rsum = rsum | bus2.rdata;
                nack++;
                if (nack == 3) drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        vec++; if (nack !== 3) begin miss++; $display("FAIL hold_ack_count: got %0d want 3", nack); end
        vec++; if (t[0] !== 3) begin miss++; $display("FAIL hold_ack1_time: got %0d want 3", t[0]); end
        vec++; if (t[1] !== 7) begin miss++; $display("FAIL hold_ack2_time: got %0d want 7", t[1]); end
        vec++; if (t[2] !== 11) begin miss++; $display("FAIL hold_ack3_time: got %0d want 11", t[2]); end
        vec++; if (rsum !== 16'h0000) begin miss++; $display("FAIL hold_rdata: got %h want 0000", rsum); end
    endtask

    initial begin
        test_reset();
        preload();
        test_write_read();
        test_back_to_back();
        test_wait_change();
        test_reset_mid();
        test_out_of_range();
        test_hold_req();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/srp16_dmem_responder.md
Name: srp16_dmem_responder

Overview:
- Data-memory responder for the SRP16 core's load/store port. This is the target end of the core's memory request interface.
- Accepts single-word read/write requests and waits a programmable number of cycles. It then returns one-cycle ack with read data.
- Lets simulation and FPGA builds model slow memory behind the core.

Parameters:
- DATA_W, 16, data word width (SRP16 word).
- ADDR_W, 16, word-address width from core.
- MEM_DEPTH, 1024, number of implemented words; must be <= 2**ADDR_W.
- WAIT_CYCLES, 2, extra wait cycles between request capture and ack (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  core request; held high until ack.
- we  input  1  1 = write, 0 = read; valid while req.
- addr  input  ADDR_W  word address; valid while req.
- wdata  input  DATA_W  write data; valid while req and we.
- ack  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  read data, valid only in ack cycle.
- busy  output  1  high from capture through ack cycle.
- err  output  1  (only with SRP16_DMEM_RANGE_CHK_EN) out-of-range flag, valid with ack.

Behaviour:
- Reset (reset low, async): state IDLE, ack=0, rdata=0, busy=0, err=0, wait counter=0. Memory array contents are not reset.
- States:
  - IDLE: on req=1 at clk edge, capture we/addr/wdata. Then go to WAIT if WAIT_CYCLES>0, else RESP. busy=1 from next cycle.
  - WAIT: counter counts 0..WAIT_CYCLES-1; at terminal count, go to RESP. req/addr changes during WAIT are ignored (captured copies used).
  - RESP: ack=1 for exactly one cycle; read returns mem[captured addr] on rdata; write commits mem[captured addr] <= captured wdata on this edge. Next state IDLE.
- Latency: req-sampled edge to ack-high = WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 gives ack on the cycle after capture.
- Back-to-back: the core drops req in the ack cycle. If req is still high in IDLE after ack, it is treated as a new request (no stale-ack suppression). Minimum one IDLE cycle between transactions.
- Read-after-write to same address in consecutive transactions returns the new data.
- Out-of-range (addr >= MEM_DEPTH), no macro: write discarded, read returns 0, timing unchanged.
- rdata returns to 0 in all cycles outside ack.
- Reset mid-transaction: transaction aborted, no ack, pending write not committed.
- Address width: only the low clog2(MEM_DEPTH) bits index the array after the range check.

Optional Feature:
- Macro SRP16_DMEM_RANGE_CHK_EN.
- Defined: err port exists; out-of-range access gets ack with err=1, rdata=0, and no write. In-range access gets err=0.
- Undefined: no err port; out-of-range behaves silently as above.

Decomposition:
- Shared package srp16_pkg: DATA_W/ADDR_W constants, state enum (S_IDLE, S_WAIT, S_RESP), request struct {we, addr, wdata}.
- One sub-module: srp16_dmem_array (synchronous single-port RAM, MEM_DEPTH x DATA_W, write-enable, registered read). The responder FSM instantiates it.

Test Plan:
- WAIT_CYCLES=2, write addr 0x0010 data 0xBEEF -> ack exactly 3 cycles after capture, busy high 3 cycles; subsequent read 0x0010 -> rdata 0xBEEF in ack cycle, 0 otherwise.
- WAIT_CYCLES=0, alternating write 0x0001=0x1234 then read 0x0001 back-to-back -> ack 1 cycle after each capture, read returns 0x1234.
- Change addr/wdata to 0x0020/0xFFFF during WAIT of write to 0x0011=0x5555 -> 0x0011 holds 0x5555, 0x0020 unchanged.
- Assert reset low during WAIT of write 0x0005=0xAAAA (prior value 0x0000) -> ack never pulses, outputs 0 immediately, later read of 0x0005 gives 0x0000.
- MEM_DEPTH=1024, write 0x0400=0x1111 then read 0x0400 -> both ack normally, read returns 0x0000; with SRP16_DMEM_RANGE_CHK_EN, err=1 in both ack cycles.
- Hold req high continuously for 3 reads of 0x0000 -> three acks, each separated by one IDLE cycle, no lost or duplicated ack.
